// File: rtl/ps2_mouse_tracker_if.sv
// Byte stream from the PS/2 receiver into the tracker, and the position/strobe bundle out to the painter.
// master = tracker side, slave = receiver/painter side.
interface ps2_mouse_tracker_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       packet_ready;
    logic [8:0] PS2_Xdata;
    logic [8:0] PS2_Ydata;
    logic [2:0] buttons;
    logic       sync_err;

    modport master (
        input  rx_data, rx_valid,
        output packet_ready, PS2_Xdata, PS2_Ydata, buttons, sync_err
    );

    modport slave (
        output rx_data, rx_valid,
        input  packet_ready, PS2_Xdata, PS2_Ydata, buttons, sync_err
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Purpose: assemble 3-byte PS/2 mouse packets and integrate deltas into a clamped absolute position.
// Latency: outputs and packet_ready appear the cycle after the third byte is sampled.
// Backpressure: none; every rx_valid byte is consumed. MOUSE_RX_TIMEOUT_EN adds an inter-byte timeout.
module ps2_mouse_tracker #(
    parameter int X_MAX  = 63,
    parameter int Y_MAX  = 63,
    parameter int X_INIT = 32,
    parameter int Y_INIT = 32
`ifdef MOUSE_RX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_mouse_tracker_if.master   bus
);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

    // Byte 0 minus its always-one sync bit.
    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] btn;
    } hdr_t;

    state_t      state, state_nxt;
    hdr_t        b0, b0_nxt;
    logic [7:0]  b1, b1_nxt;
    logic [8:0]  x_q, x_nxt, y_q, y_nxt;
    logic [2:0]  btn_q, btn_nxt;
    logic        pr_q, pr_nxt, se_q, se_nxt;
    logic        timeout;

    logic signed [8:0] dx, dy;
    logic signed [9:0] sx, sy;

    function automatic logic [8:0] clamp(input logic signed [9:0] s, input int max_v);
        if (s < 0)
            return '0;
        else if (s > max_v)
            return 9'(max_v);
        else
            return s[8:0];
    endfunction

    // The third byte is used straight off the bus so the update lands on the edge that samples it.
    assign dx = b0.x_ovf ? 9'sd0 : $signed({b0.x_sign, b1});
    assign dy = b0.y_ovf ? 9'sd0 : $signed({b0.y_sign, bus.rx_data});
    assign sx = $signed({1'b0, x_q}) + $signed({dx[8], dx});
    assign sy = $signed({1'b0, y_q}) - $signed({dy[8], dy});

`ifdef MOUSE_RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || bus.rx_valid || !(state == WAIT_B1 || state == WAIT_B2))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign timeout = (state == WAIT_B1 || state == WAIT_B2) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        b0_nxt    = b0;
        b1_nxt    = b1;
        x_nxt     = x_q;
        y_nxt     = y_q;
        btn_nxt   = btn_q;
        pr_nxt    = 1'b0;
        se_nxt    = 1'b0;
        unique case (state)
            WAIT_B0, UPDATE: begin
                state_nxt = WAIT_B0;
                if (bus.rx_valid) begin
                    if (bus.rx_data[3]) begin
                        b0_nxt    = hdr_t'({bus.rx_data[7:4], bus.rx_data[2:0]});
                        state_nxt = WAIT_B1;
                    end else begin
                        se_nxt = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (bus.rx_valid) begin
                    b1_nxt    = bus.rx_data;
                    state_nxt = WAIT_B2;
                end else if (timeout) begin
                    state_nxt = WAIT_B0;
                    se_nxt    = 1'b1;
                end
            end
            WAIT_B2: begin
                if (bus.rx_valid) begin
                    x_nxt     = clamp(sx, X_MAX);
                    y_nxt     = clamp(sy, Y_MAX);
                    btn_nxt   = b0.btn;
                    pr_nxt    = 1'b1;
                    state_nxt = UPDATE;
                end else if (timeout) begin
                    state_nxt = WAIT_B0;
                    se_nxt    = 1'b1;
                end
            end
            default: state_nxt = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_B0;
            b0    <= '0;
            b1    <= '0;
            x_q   <= 9'(X_INIT);
            y_q   <= 9'(Y_INIT);
            btn_q <= '0;
            pr_q  <= 1'b0;
            se_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            b0    <= b0_nxt;
            b1    <= b1_nxt;
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            btn_q <= btn_nxt;
            pr_q  <= pr_nxt;
            se_q  <= se_nxt;
        end
    end

    assign bus.packet_ready = pr_q;
    assign bus.PS2_Xdata    = x_q;
    assign bus.PS2_Ydata    = y_q;
    assign bus.buttons      = btn_q;
    assign bus.sync_err     = se_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: directed packets push expected positions, a monitor pops on packet_ready.
module tb_ps2_mouse_tracker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_mouse_tracker_if bus();

`ifdef MOUSE_RX_TIMEOUT_EN
    ps2_mouse_tracker #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    ps2_mouse_tracker dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] b;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   se_seen = 0;
    int   se_exp  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every packet_ready pops one expectation; latency is checked against the issue cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.packet_ready === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected packet_ready", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("PS2_Xdata", 32'(bus.PS2_Xdata), 32'(mon_e.x));
                    check("PS2_Ydata", 32'(bus.PS2_Ydata), 32'(mon_e.y));
                    check("buttons",   32'(bus.buttons),   32'(mon_e.b));
                    check("latency",   32'(cyc),           32'(mon_e.cyc));
                end
            end
            if (bus.sync_err === 1'b1) se_seen++;
        end
    end

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'h00;
        end
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input int ex, input int ey, input int eb, input int gap);
        drive(b0);
        idle(gap);
        drive(b1);
        idle(gap);
        drive(b2);
        q.push_back('{x: 9'(ex), y: 9'(ey), b: 3'(eb), cyc: cyc + 1});
        idle(gap);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset PS2_Xdata",    32'(bus.PS2_Xdata),    32);
        check("reset PS2_Ydata",    32'(bus.PS2_Ydata),    32);
        check("reset buttons",      32'(bus.buttons),      0);
        check("reset packet_ready", 32'(bus.packet_ready), 0);
        check("reset sync_err",     32'(bus.sync_err),     0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        apply_reset();

        pkt(8'h08, 8'h05, 8'h03, 37, 29, 0, 1);
        pkt(8'h38, 8'hF6, 8'hFE, 27, 31, 0, 1);

        apply_reset();
        pkt(8'h09, 8'h7F, 8'h00, 63, 32, 1, 1);
        pkt(8'h18, 8'h80, 8'h00,  0, 32, 0, 1);

        // Byte without the sync bit is dropped, then a normal packet.
        drive(8'h05);
        se_exp++;
        idle(1);
        pkt(8'h08, 8'h01, 8'h01, 1, 31, 0, 1);

        // X overflow: dx ignored.
        pkt(8'h48, 8'h10, 8'h02, 1, 29, 0, 1);

        // Back-to-back packets: next byte 0 arrives during the update cycle; Y clamps both ways.
        pkt(8'h28, 8'h00, 8'h80, 1, 63, 0, 0);
        pkt(8'h0A, 8'h00, 8'h7F, 1,  0, 2, 0);
        pkt(8'h88, 8'h05, 8'h40, 6,  0, 0, 0);
        idle(3);

        // Reset mid-packet discards the partial bytes; 0x01 must then be a rejected byte 0.
        drive(8'h08);
        drive(8'h05);
        apply_reset();
        drive(8'h01);
        se_exp++;
        idle(1);
        pkt(8'h0C, 8'h02, 8'h00, 34, 32, 4, 1);

`ifdef MOUSE_RX_TIMEOUT_EN
        drive(8'h08);
        idle(110);
        se_exp++;
        pkt(8'h08, 8'h02, 8'h00, 36, 32, 0, 1);
`endif

        idle(5);
        check("pending packets", 32'(q.size()), 0);
        check("sync_err pulses", 32'(se_seen), 32'(se_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
